input_conditioner: RTL

Board-input front end that sits directly upstream of the CPU datapath, on the raw board clock `clk`. It synchronises and debounces push-buttons and slide switches. It produces clean levels plus one-cycle press/release pulses, and a latched run/stop state that drives the datapath's stop_button input. It also produces a single-step pulse so a halted CPU can be advanced one instruction per button press.

---
 rtl/input_conditioner.sv | 68 ++++++
 1 files changed

// File: rtl/input_conditioner.sv
// input_conditioner: synchronise and debounce buttons/switches, derive press/release pulses, run/stop and single-step
module input_conditioner #(
  parameter int NUM_BTN         = 4,
  parameter int SW_WIDTH        = 8,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_WIDTH       = 20,
  parameter int STOP_IDX        = 0,
  parameter int STEP_IDX        = 1
) (
  input  logic                clk,
  input  logic                RST,
  input  logic [NUM_BTN-1:0]  raw_btn,
  input  logic [SW_WIDTH-1:0] raw_sw,
  output logic [NUM_BTN-1:0]  btn_level,
  output logic [NUM_BTN-1:0]  btn_press,
  output logic [NUM_BTN-1:0]  btn_release,
  output logic [SW_WIDTH-1:0] sw_level,
  output logic                stop_state,
  output logic                step_pulse
);
  localparam int W = NUM_BTN + SW_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  logic [W-1:0] s1, s2, stable;
  logic [W-1:0][CNT_WIDTH-1:0] cnt;
  logic [NUM_BTN-1:0] btn_d;
  always_ff @(posedge clk) begin
    if (RST) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= {raw_sw, raw_btn};
      s2 <= s1;
    end
  end
  // any cycle agreeing with the accepted level restarts the stability count
  always_ff @(posedge clk) begin
    if (RST) begin
      stable <= '0;
      cnt    <= '0;
    end else begin
      for (int i = 0; i < W; i++) begin
        if (s2[i] == stable[i]) cnt[i] <= '0;
        else if (cnt[i] == LAST) begin
          stable[i] <= s2[i];
          cnt[i]    <= '0;
        end else cnt[i] <= cnt[i] + CNT_WIDTH'(1);
      end
    end
  end
  assign btn_level = stable[NUM_BTN-1:0];
  assign sw_level  = stable[W-1:NUM_BTN];
  // step samples stop_state before this cycle's toggle
  always_ff @(posedge clk) begin
    if (RST) begin
      btn_d       <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      stop_state  <= 1'b0;
      step_pulse  <= 1'b0;
    end else begin
      btn_d       <= btn_level;
      btn_press   <= btn_level & ~btn_d;
      btn_release <= ~btn_level & btn_d;
      stop_state  <= stop_state ^ btn_press[STOP_IDX];
      step_pulse  <= btn_press[STEP_IDX] & stop_state;
    end
  end
endmodule
